// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one 32-bit adder among NREQ requesters, holding the
// granted operands for SETTLE cycles before capturing sum and carry-out.
// Build option: ADDER_ARB_RR_EN selects round-robin grant; when it is not
// defined, grant is fixed priority with the lowest index winning.
module adder_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned IDW    = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  input  logic [31:0]        add_s,
  input  logic               add_cout,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_sum,
  output logic               rsp_cout,
  output logic               busy
);
  localparam int unsigned CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] gnt;
  logic           any_req;
  logic           xfer;
  logic           capture;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;

`ifdef ADDER_ARB_RR_EN
  logic [IDW-1:0] last;
  logic [IDW:0]   scan;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    scan    = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      scan = (IDW+1)'(last) + (IDW+1)'(i + 1);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (!any_req && req_valid[scan[IDW-1:0]]) begin
        any_req = 1'b1;
        gnt     = scan[IDW-1:0];
      end
    end
  end

  // Pointer remembers the most recent grant; reset makes requester 0 first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= IDW'(NREQ - 1);
    else if (xfer) last <= gnt;
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        gnt     = IDW'(i);
      end
    end
  end
`endif

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == gnt) begin
        sel_a = req_a[i*32 +: 32];
        sel_b = req_b[i*32 +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state, accept handshake and capture strobe.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    xfer      = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req && rst_n) begin
          req_ready = NREQ'(1) << gnt;
          xfer      = req_valid[gnt];
          if (xfer) state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == CW'(1)) begin
          capture  = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand, settle counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a     <= '0;
      add_b     <= '0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= capture;
      if (xfer) begin
        add_a  <= sel_a;
        add_b  <= sel_b;
        rsp_id <= gnt;
        cnt    <= CW'(SETTLE);
        busy   <= 1'b1;
      end else if (state == ST_SETTLE) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        rsp_sum  <= add_s;
        rsp_cout <= add_cout;
      end
      if (state == ST_RESP) busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter; grant order follows ADDER_ARB_RR_EN.
module tb_adder_arbiter;
  localparam int NR = 4;
  localparam int ST = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*32-1:0]  req_a, req_b;
  logic [31:0]       add_a, add_b, add_s, rsp_sum;
  logic              add_cout, rsp_valid, rsp_cout, busy;
  logic [1:0]        rsp_id;

  logic [NR-1:0]     v1, ready1;
  logic [NR*32-1:0]  ra1, rb1;
  logic [31:0]       aa1, ab1, as1, rsum1;
  logic              ac1, rv1, rc1, busy1;
  logic [1:0]        rid1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_last = NR - 1;

  adder_arbiter #(.NREQ(NR), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b),
    .add_s(add_s), .add_cout(add_cout), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy));

  adder_arbiter #(.NREQ(NR), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
    .req_a(ra1), .req_b(rb1), .add_a(aa1), .add_b(ab1),
    .add_s(as1), .add_cout(ac1), .rsp_valid(rv1),
    .rsp_id(rid1), .rsp_sum(rsum1), .rsp_cout(rc1), .busy(busy1));

  // The shared adder itself.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};
  assign {ac1, as1}        = {1'b0, aa1} + {1'b0, ab1};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
    req_a[k*32 +: 32] = a;
    req_b[k*32 +: 32] = b;
  endtask

  // Reference grant: first requester at or after the search start.
  function automatic int model_grant(input logic [NR-1:0] v);
`ifdef ADDER_ARB_RR_EN
    for (int k = 1; k <= NR; k++) if (v[(exp_last + k) % NR]) return (exp_last + k) % NR;
`else
    for (int k = 0; k < NR; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic do_reset();
    req_valid = '0;
    v1        = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    exp_last = NR - 1;
  endtask

  // Waits for a response pulse on the main instance, bounded.
  task automatic wait_rsp(output bit ok, output logic [1:0] id, output logic [31:0] s,
                          output bit c, output int cyc);
    ok = 1'b0; id = '0; s = '0; c = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1; id = rsp_id; s = rsp_sum; c = rsp_cout;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; v1 = '0; req_a = '1; req_b = '1; ra1 = '0; rb1 = '0;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++; if ({add_a, add_b} !== 64'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h want 0 0", add_a, add_b); end
    n_checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, busy} !== 37'd0) begin n_fail++;
      $display("FAIL reset_rsp: got v=%b id=%0d s=%h c=%b busy=%b want all 0", rsp_valid, rsp_id, rsp_sum, rsp_cout, busy); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    bit ok; logic [1:0] id; logic [31:0] s; bit c; int cyc;
    @(negedge clk);
    set_req(1, 32'h5, 32'h7); req_valid = 4'b0010; #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    @(negedge clk); req_valid = '0; exp_last = 1;
    n_checks++; if ({busy, add_a, add_b} !== {1'b1, 32'h5, 32'h7}) begin n_fail++;
      $display("FAIL single_operands: got busy=%b a=%h b=%h want 1 5 7", busy, add_a, add_b); end
    wait_rsp(ok, id, s, c, cyc);
    n_checks++; if (!ok || cyc != ST) begin n_fail++; $display("FAIL single_latency: got ok=%0d cyc=%0d want 1 %0d", ok, cyc, ST); end
    n_checks++; if ({id, s, c} !== {2'd1, 32'hC, 1'b0}) begin n_fail++;
      $display("FAIL single_result: got id=%0d s=%h c=%b want 1 0000000c 0", id, s, c); end
    @(negedge clk);
    n_checks++; if ({rsp_valid, busy, rsp_sum} !== {2'b00, 32'hC}) begin n_fail++;
      $display("FAIL single_after: got v=%b busy=%b s=%h want 0 0 0000000c", rsp_valid, busy, rsp_sum); end
  endtask

  task automatic test_carry();
    bit ok; logic [1:0] id; logic [31:0] s; bit c; int cyc;
    @(negedge clk);
    set_req(3, 32'hFFFF_FFFF, 32'h1); req_valid = 4'b1000; #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL carry_ready: got %b want 1000", req_ready); end
    @(negedge clk); req_valid = '0; exp_last = 3;
    wait_rsp(ok, id, s, c, cyc);
    n_checks++; if (!ok || {id, s, c} !== {2'd3, 32'h0, 1'b1}) begin n_fail++;
      $display("FAIL carry_result: got ok=%0d id=%0d s=%h c=%b want 1 3 00000000 1", ok, id, s, c); end
  endtask

  task automatic test_arbitration();
    int exp_order[5]; int n_exp; int got; int prev; bit drop;
    logic [NR-1:0] er;
    do_reset();
    for (int k = 0; k < NR; k++) set_req(k, 32'(k), 32'(k * 16));
`ifdef ADDER_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0}; n_exp = 5; req_valid = 4'b1111;
`else
    exp_order = '{0, 0, 0, 2, 0}; n_exp = 4; req_valid = 4'b0101;
`endif
    got = 0; prev = 0; drop = 1'b0;
    for (int cyc = 0; cyc < 60 && got < n_exp; cyc++) begin
      if (drop) begin req_valid[0] = 1'b0; drop = 1'b0; end
      #1;
      if (req_ready !== '0) begin
        er = NR'(1) << exp_order[got];
        n_checks++; if (req_ready !== er) begin n_fail++; $display("FAIL arb_grant%0d: got %b want %b", got, req_ready, er); end
        if (got > 0) begin
          n_checks++; if (cyc - prev != ST + 2) begin n_fail++; $display("FAIL arb_spacing%0d: got %0d want %0d", got, cyc - prev, ST + 2); end
        end
        prev = cyc; got++;
`ifndef ADDER_ARB_RR_EN
        if (got == 3) drop = 1'b1;
`endif
      end
      @(negedge clk);
    end
    n_checks++; if (got != n_exp) begin n_fail++; $display("FAIL arb_count: got %0d grants want %0d", got, n_exp); end
    req_valid = '0;
    repeat (ST + 3) @(negedge clk);
  endtask

  task automatic test_random();
    bit pend[NR]; logic [31:0] pa[NR]; logic [31:0] pb[NR];
    bit ok; logic [1:0] id; logic [31:0] s; bit c; int cyc; int g; bit anyp;
    logic [NR-1:0] er; logic [32:0] es;
    do_reset();
    for (int k = 0; k < NR; k++) pend[k] = 1'b0;
    for (int op = 0; op < 30; op++) begin
      @(negedge clk);
      anyp = 1'b0;
      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin pend[k] = 1'b1; pa[k] = $urandom; pb[k] = $urandom; end
        anyp = anyp | pend[k];
      end
      if (!anyp) begin g = int'($urandom_range(0, NR - 1)); pend[g] = 1'b1; pa[g] = $urandom; pb[g] = $urandom; end
      for (int k = 0; k < NR; k++) begin req_valid[k] = pend[k]; set_req(k, pa[k], pb[k]); end
      #1;
      g  = model_grant(req_valid);
      er = NR'(1) << g;
      n_checks++; if (req_ready !== er || busy !== 1'b0) begin n_fail++;
        $display("FAIL rand_grant%0d: got %b busy=%b want %b busy=0", op, req_ready, busy, er); end
      @(negedge clk);
      pend[g] = 1'b0; req_valid[g] = 1'b0; exp_last = g;
      n_checks++; if (req_ready !== '0 || add_a !== pa[g] || add_b !== pb[g]) begin n_fail++;
        $display("FAIL rand_settle%0d: got rdy=%b a=%h b=%h want 0 %h %h", op, req_ready, add_a, add_b, pa[g], pb[g]); end
      wait_rsp(ok, id, s, c, cyc);
      es = {1'b0, pa[g]} + {1'b0, pb[g]};
      n_checks++; if (!ok || cyc != ST || {id, c, s} !== {2'(g), es}) begin n_fail++;
        $display("FAIL rand_rsp%0d: got ok=%0d cyc=%0d id=%0d c=%b s=%h want 1 %0d %0d %b %h", op, ok, cyc, id, c, s, ST, g, es[32], es[31:0]); end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit ok; logic [1:0] id; logic [31:0] s; bit c; int cyc; int seen;
    @(negedge clk);
    set_req(2, 32'h100, 32'h200); req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b1111; rst_n = 1'b0; #1;
    n_checks++; if ({req_ready, busy, rsp_valid, add_a, add_b, rsp_id, rsp_sum, rsp_cout} !== '0) begin n_fail++;
      $display("FAIL midrst_values: got rdy=%b busy=%b v=%b a=%h b=%h id=%0d s=%h c=%b want all 0",
               req_ready, busy, rsp_valid, add_a, add_b, rsp_id, rsp_sum, rsp_cout); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
    req_valid = '0; rst_n = 1'b1; exp_last = NR - 1;
    repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_norsp: got %0d pulses want 0", seen); end
    set_req(0, 32'h1234_5678, 32'h1111_1111); set_req(1, 32'h9, 32'h9); req_valid = 4'b0011; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant: got %b want 0001", req_ready); end
    @(negedge clk); req_valid = '0; exp_last = 0;
    wait_rsp(ok, id, s, c, cyc);
    n_checks++; if (!ok || {id, s, c} !== {2'd0, 32'h2345_6789, 1'b0}) begin n_fail++;
      $display("FAIL midrst_result: got ok=%0d id=%0d s=%h c=%b want 1 0 23456789 0", ok, id, s, c); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [32:0] q[$]; logic [32:0] e; int last_rsp; int nrsp; bit acc;
    last_rsp = -1; nrsp = 0; acc = 1'b0;
    @(negedge clk);
    ra1[31:0] = $urandom; rb1[31:0] = $urandom; v1 = 4'b0001;
    for (int cyc = 0; cyc < 60 && nrsp < 6; cyc++) begin
      #1;
      if (rv1) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected: got rsp with no accept want none"); end
        else begin
          e = q.pop_front();
          if ({rc1, rsum1} !== e || rid1 !== 2'd0) begin n_fail++;
            $display("FAIL b2b_result%0d: got id=%0d c=%b s=%h want 0 %b %h", nrsp, rid1, rc1, rsum1, e[32], e[31:0]); end
        end
        if (last_rsp >= 0) begin
          n_checks++; if (cyc - last_rsp != 3) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 3", nrsp, cyc - last_rsp); end
        end
        last_rsp = cyc; nrsp++;
      end
      if (ready1[0]) begin q.push_back({1'b0, ra1[31:0]} + {1'b0, rb1[31:0]}); acc = 1'b1; end
      @(negedge clk);
      if (acc) begin ra1[31:0] = $urandom; rb1[31:0] = $urandom; acc = 1'b0; end
    end
    n_checks++; if (nrsp != 6) begin n_fail++; $display("FAIL b2b_count: got %0d responses want 6", nrsp); end
    v1 = '0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_carry();
    test_arbitration();
    test_random();
    test_reset_mid_op();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
